// File: rtl/mem_wb_forward_source.sv
// EX/MEM and MEM/WB pipeline registers with a ready-handshaked data-memory controller.
// Drives both EX-stage forwarding sources and stalls upstream while an access is pending.
module mem_wb_forward_source #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               RegWrite_ex,
  input  logic               MemRead_ex,
  input  logic               MemWrite_ex,
  input  logic               MemtoReg_ex,
  input  logic [RADDR_W-1:0] RegWriteAddr_ex,
  input  logic [DATA_W-1:0]  ALUResult_ex,
  input  logic [DATA_W-1:0]  MemWriteData_ex,
  output logic               RegWrite_mem,
  output logic [RADDR_W-1:0] RegWriteAddr_mem,
  output logic [DATA_W-1:0]  ALUResult_mem,
  output logic               MemRead_mem,
  output logic               RegWrite_wb,
  output logic [RADDR_W-1:0] RegWriteAddr_wb,
  output logic [DATA_W-1:0]  RegWriteData_wb,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ready,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               mem_stall
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                mem_write_q;
  logic                mem_to_reg_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                mem_access;
  logic [DATA_W-1:0]   wb_data_d;

  // Request fields come straight from EX/MEM, which is frozen while stalled,
  // so they stay stable until dmem_ready.
  always_comb begin
    mem_access = MemRead_mem | mem_write_q;
    dmem_req   = mem_access & ((state_q == S_IDLE) | (state_q == S_WAIT));
    dmem_we    = mem_write_q;
    dmem_addr  = ALUResult_mem;
    dmem_wdata = mem_wdata_q;
    mem_stall  = mem_access & ~dmem_ready;
    wb_data_d  = mem_to_reg_q ? dmem_rdata : ALUResult_mem;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (mem_access && !dmem_ready) state_d = S_WAIT;
      S_WAIT: if (dmem_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // EX/MEM register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      RegWrite_mem     <= 1'b0;
      MemRead_mem      <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_to_reg_q     <= 1'b0;
      RegWriteAddr_mem <= '0;
      ALUResult_mem    <= '0;
      mem_wdata_q      <= '0;
    end else if (!mem_stall) begin
      RegWrite_mem     <= RegWrite_ex;
      MemRead_mem      <= MemRead_ex;
      mem_write_q      <= MemWrite_ex;
      mem_to_reg_q     <= MemtoReg_ex;
      RegWriteAddr_mem <= RegWriteAddr_ex;
      ALUResult_mem    <= ALUResult_ex;
      mem_wdata_q      <= MemWriteData_ex;
    end
  end

  // MEM/WB register; holding it during a stall keeps the wb forwarding source valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      RegWrite_wb     <= 1'b0;
      RegWriteAddr_wb <= '0;
      RegWriteData_wb <= '0;
    end else if (!mem_stall) begin
      RegWrite_wb     <= RegWrite_mem;
      RegWriteAddr_wb <= RegWriteAddr_mem;
      RegWriteData_wb <= wb_data_d;
    end
  end

endmodule

// File: tb/tb_mem_wb_forward_source.sv
// Randomized bench for mem_wb_forward_source: a transaction-level pipeline model
// with a wait-state memory predicts every observable output each cycle.
module tb_mem_wb_forward_source;

  typedef struct {
    logic        rw, mr, mw, mtr;
    logic [4:0]  rd;
    logic [31:0] alu, wd;
  } ins_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RegWrite_ex = 1'b0, MemRead_ex = 1'b0, MemWrite_ex = 1'b0, MemtoReg_ex = 1'b0;
  logic [4:0]  RegWriteAddr_ex = '0;
  logic [31:0] ALUResult_ex = '0, MemWriteData_ex = '0;
  logic        RegWrite_mem, MemRead_mem, RegWrite_wb;
  logic [4:0]  RegWriteAddr_mem, RegWriteAddr_wb;
  logic [31:0] ALUResult_mem, RegWriteData_wb;
  logic        dmem_req, dmem_we, mem_stall;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = '0;

  mem_wb_forward_source #(.DATA_W(32), .RADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex), .MemWrite_ex(MemWrite_ex),
    .MemtoReg_ex(MemtoReg_ex), .RegWriteAddr_ex(RegWriteAddr_ex),
    .ALUResult_ex(ALUResult_ex), .MemWriteData_ex(MemWriteData_ex),
    .RegWrite_mem(RegWrite_mem), .RegWriteAddr_mem(RegWriteAddr_mem),
    .ALUResult_mem(ALUResult_mem), .MemRead_mem(MemRead_mem),
    .RegWrite_wb(RegWrite_wb), .RegWriteAddr_wb(RegWriteAddr_wb),
    .RegWriteData_wb(RegWriteData_wb),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // model state: instruction sitting in MEM, contents of WB, remaining wait cycles
  ins_t        m_mem;
  logic        m_wb_rw;
  logic [4:0]  m_wb_rd;
  logic [31:0] m_wb_data;
  int          waits_left = 0;
  bit          model_valid = 0;
  int          stall_cycles = 0;
  int          completions = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic ins_t mk(input int kind, input logic [4:0] rd,
                              input logic [31:0] alu, input logic [31:0] wd);
    ins_t r;
    r.rw = (kind == 1) || (kind == 2);
    r.mr = (kind == 2);
    r.mw = (kind == 3);
    r.mtr = (kind == 2);
    r.rd = (kind == 0) ? 5'd0 : rd;
    r.alu = (kind == 0) ? 32'd0 : alu;
    r.wd = (kind == 3) ? wd : ((kind == 0) ? 32'd0 : wd);
    return r;
  endfunction

  // kind: 0 bubble, 1 ALU, 2 load, 3 store
  task automatic step(input bit rst, input ins_t ex, input int waits_ex, input logic [31:0] rdata);
    bit   access, ready, exp_stall;
    @(negedge clk);
    rst_n           = rst;
    RegWrite_ex     = ex.rw;
    MemRead_ex      = ex.mr;
    MemWrite_ex     = ex.mw;
    MemtoReg_ex     = ex.mtr;
    RegWriteAddr_ex = ex.rd;
    ALUResult_ex    = ex.alu;
    MemWriteData_ex = ex.wd;
    access = model_valid && (m_mem.mr || m_mem.mw);
    ready  = access ? (waits_left == 0) : 1'($urandom_range(1, 0));
    dmem_ready = ready;
    dmem_rdata = rdata;
    exp_stall  = access && !ready;
    #1;
    if (model_valid) begin
      chk("RegWrite_mem", 32'(RegWrite_mem), 32'(m_mem.rw));
      chk("RegWriteAddr_mem", 32'(RegWriteAddr_mem), 32'(m_mem.rd));
      chk("ALUResult_mem", ALUResult_mem, m_mem.alu);
      chk("MemRead_mem", 32'(MemRead_mem), 32'(m_mem.mr));
      chk("RegWrite_wb", 32'(RegWrite_wb), 32'(m_wb_rw));
      chk("RegWriteAddr_wb", 32'(RegWriteAddr_wb), 32'(m_wb_rd));
      chk("RegWriteData_wb", RegWriteData_wb, m_wb_data);
      chk("dmem_req", 32'(dmem_req), 32'(access));
      chk("mem_stall", 32'(mem_stall), 32'(exp_stall));
      if (access) begin
        chk("dmem_we", 32'(dmem_we), 32'(m_mem.mw));
        chk("dmem_addr", dmem_addr, m_mem.alu);
        chk("dmem_wdata", dmem_wdata, m_mem.wd);
      end
    end
    $display("cyc t=%0t rst_n=%0b ex(rw=%0b mr=%0b mw=%0b rd=%0d alu=%08h) req=%0b rdy=%0b stall=%0b wb(%0b r%0d %08h)",
             $time, rst, ex.rw, ex.mr, ex.mw, ex.rd, ex.alu, dmem_req, ready, mem_stall,
             RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb);
    @(posedge clk);
    if (!rst) begin
      m_mem = mk(0, 5'd0, 32'd0, 32'd0);
      m_wb_rw = 1'b0; m_wb_rd = '0; m_wb_data = '0;
      waits_left = 0;
      model_valid = 1;
    end else if (exp_stall) begin
      waits_left--;
      stall_cycles++;
    end else begin
      if (access) completions++;
      m_wb_rw   = m_mem.rw;
      m_wb_rd   = m_mem.rd;
      m_wb_data = m_mem.mtr ? rdata : m_mem.alu;
      m_mem     = ex;
      waits_left = waits_ex;
    end
  endtask

  ins_t bub;

  initial begin
    bub = mk(0, 5'd0, 32'd0, 32'd0);
    step(0, bub, 0, 32'd0);
    step(0, bub, 0, 32'd0);
    // ALU r5 <= 0xA5
    step(1, mk(1, 5'd5, 32'h0000_00A5, 32'd0), 0, 32'd0);
    step(1, bub, 0, 32'd0);
    step(1, bub, 0, 32'd0);
    step(1, bub, 0, 32'd0);
    // zero-wait load from 0x100
    step(1, mk(2, 5'd2, 32'h100, 32'd0), 0, 32'd0);
    step(1, bub, 0, 32'hDEADBEEF);
    step(1, bub, 0, 32'd0);
    // store to 0x40 with three wait cycles
    step(1, mk(3, 5'd0, 32'h40, 32'h1234), 3, 32'd0);
    repeat (6) step(1, bub, 0, $urandom);
    // load r7 with r3 ALU result already in WB, two wait cycles
    step(1, mk(1, 5'd3, 32'h3333_0003, 32'd0), 0, 32'd0);
    step(1, mk(2, 5'd7, 32'h200, 32'd0), 2, 32'd0);
    step(1, bub, 0, 32'hBAD0_0001);
    step(1, bub, 0, 32'hBAD0_0002);
    step(1, bub, 0, 32'h7777_0007);
    step(1, bub, 0, 32'd0);
    // reset while waiting on a store
    step(1, mk(3, 5'd0, 32'h80, 32'h5555), 3, 32'd0);
    step(1, bub, 0, 32'd0);
    step(0, bub, 0, 32'd0);
    step(1, mk(1, 5'd9, 32'h99, 32'd0), 0, 32'd0);
    step(1, bub, 0, 32'd0);
    step(1, bub, 0, 32'd0);
    // back-to-back zero-wait loads
    step(1, mk(2, 5'd1, 32'h10, 32'd0), 0, 32'd0);
    step(1, mk(2, 5'd2, 32'h14, 32'd0), 0, 32'h1111_1111);
    step(1, bub, 0, 32'h2222_2222);
    step(1, bub, 0, 32'd0);
    step(1, bub, 0, 32'd0);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      ins_t r;
      r = mk(int'($urandom_range(3, 0)), 5'($urandom), $urandom, $urandom);
      step(($urandom_range(59, 0) != 0), r, int'($urandom_range(3, 0)), $urandom);
    end
    step(1, bub, 0, 32'd0);
    if (completions == 0 || stall_cycles == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL coverage: completions=%0d stall_cycles=%0d required both nonzero",
               completions, stall_cycles);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_forward_source.md
Name: mem_wb_forward_source

Overview:
- EX/MEM and MEM/WB pipeline registers plus the data-memory access controller.
- It is the producer end of the EX-stage forwarding interface. It drives RegWrite_mem, RegWriteAddr_mem and ALUResult_mem (forwarding source 2), and RegWrite_wb, RegWriteAddr_wb and RegWriteData_wb (forwarding source 1).
- It sequences loads and stores over a ready-handshaked data-memory port. While an access is outstanding it stalls upstream stages.

Parameters:
- DATA_W, 32, datapath and memory word width.
- RADDR_W, 5, register-file address width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- RegWrite_ex  in  1  EX instruction writes the register file.
- MemRead_ex  in  1  EX instruction is a load.
- MemWrite_ex  in  1  EX instruction is a store.
- MemtoReg_ex  in  1  writeback selects load data (1) or ALU result (0).
- RegWriteAddr_ex  in  RADDR_W  destination register.
- ALUResult_ex  in  DATA_W  ALU result; this is the memory byte address for loads/stores.
- MemWriteData_ex  in  DATA_W  store data (already forwarded).
- RegWrite_mem  out  1  registered RegWrite_ex.
- RegWriteAddr_mem  out  RADDR_W  registered RegWriteAddr_ex.
- ALUResult_mem  out  DATA_W  registered ALUResult_ex.
- MemRead_mem  out  1  load in MEM; consumed by the load-use hazard unit.
- RegWrite_wb  out  1  writeback enable.
- RegWriteAddr_wb  out  RADDR_W  writeback register.
- RegWriteData_wb  out  DATA_W  writeback data.
- dmem_req  out  1  memory request valid.
- dmem_we  out  1  1 = write, 0 = read.
- dmem_addr  out  DATA_W  byte address.
- dmem_wdata  out  DATA_W  write data.
- dmem_ready  in  1  access completes this cycle.
- dmem_rdata  in  DATA_W  read data; valid when dmem_ready=1 on a read.
- mem_stall  out  1  freeze IF/ID/EX and the EX/MEM input.

Behaviour:
- Reset (rst_n=0 at a clock edge): all *_mem and *_wb registers go to 0 (control, addresses, data). FSM goes to IDLE. Combinationally this forces dmem_req=0 and mem_stall=0. Reset overrides stall, including mid-access: the request drops the cycle after the reset edge and the access is abandoned.
- EX/MEM register holds RegWrite, MemRead, MemWrite, MemtoReg, RegWriteAddr, ALUResult and MemWriteData.
  - Loads when mem_stall=0; holds when mem_stall=1.
  - Latency EX→MEM is 1 cycle.
- Memory access signals:
  - mem_access = MemRead_mem | MemWrite_mem.
  - dmem_req = mem_access & (state==IDLE | state==WAIT).
  - dmem_we = MemWrite_mem; dmem_addr = ALUResult_mem; dmem_wdata = MemWriteData_mem.
  - All request fields are stable while dmem_req=1 and dmem_ready=0.
- FSM states: IDLE, WAIT.
  - IDLE, mem_access=1, dmem_ready=1: zero-wait completion; stay IDLE, mem_stall=0.
  - IDLE, mem_access=1, dmem_ready=0: go to WAIT, mem_stall=1.
  - WAIT, dmem_ready=0: stay WAIT, mem_stall=1.
  - WAIT, dmem_ready=1: return to IDLE, mem_stall=0.
  - Net rule: mem_stall = mem_access & ~dmem_ready. Each access completes exactly once; no second request is issued for the same instruction.
- MEM/WB register holds RegWrite, RegWriteAddr and WriteData.
  - WriteData = MemtoReg_mem ? dmem_rdata : ALUResult_mem.
  - Loads when mem_stall=0; holds when mem_stall=1. Holding keeps the wb forwarding source alive for the frozen EX instruction, and repeating the register-file write is idempotent.
  - Latency MEM→WB is 1 cycle, so an ALU op reaches WB 2 edges after leaving EX.
- Stores never assert RegWrite_wb (follows RegWrite_mem, which decode sets to 0).
- Writes to register 0 pass through unchanged; the consumers filter address 0.
- No flush input: bubbles arrive from upstream as all-zero control.
- Simultaneous events:
  - dmem_ready asserted while dmem_req=0: ignored.
  - Back-to-back loads with zero-wait memory: one per cycle, no stall.
  - Load followed by a load with 2 wait cycles: the second stalls for exactly 2 cycles.

Test Plan:
- ALU op, RegWrite_ex=1, addr=5, ALUResult_ex=0x0000_00A5, no memory op -> next edge: RegWrite_mem=1, RegWriteAddr_mem=5, ALUResult_mem=0xA5. Following edge: RegWrite_wb=1, RegWriteAddr_wb=5, RegWriteData_wb=0xA5. mem_stall stays 0 throughout.
- Load addr=0x100, dmem_ready=1 same cycle, dmem_rdata=0xDEADBEEF -> dmem_req=1, dmem_we=0 for 1 cycle; no stall. Next edge: RegWriteData_wb=0xDEADBEEF.
- Store addr=0x40, data=0x1234, dmem_ready low 3 cycles -> dmem_req=1, dmem_we=1 for 4 cycles with addr/wdata stable; mem_stall=1 for 3 cycles. *_mem and *_wb registers unchanged during the stall; RegWrite_wb for the store is 0 after completion.
- Load to r7 while r3 ALU result sits in WB, 2 wait cycles -> RegWrite_wb=1, RegWriteAddr_wb=3 and RegWriteData_wb held for both stall cycles. Then r7 with load data appears in WB.
- rst_n=0 during WAIT -> next cycle: dmem_req=0, mem_stall=0, all *_mem and *_wb outputs 0. After release, a new ALU op flows normally.
- Back-to-back loads r1, r2 with zero-wait memory -> two consecutive dmem_req cycles, no stall, WB shows r1 then r2 on consecutive cycles.
